proc_ctrl_unit: RTL and testbench

//  Parametrised multicycle control unit for the simple bus-based processor.

---
 rtl/proc_ctrl_pkg.sv | 33 +++
 rtl/onehot_dec.sv | 12 +
 rtl/proc_ctrl_unit.sv | 146 ++++++++++++++
 tb/tb_proc_ctrl_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared types for the multicycle processor control unit: opcodes, FSM states
// and ALU operation codes driven onto the datapath.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100,
    OP_AND  = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_T1   = 2'b01,
    S_T2   = 2'b10,
    S_T3   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10
  } alu_op_t;

  function automatic logic is_alu_op(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary register index to one-hot select vector.
module onehot_dec #(
  parameter int N  = 8,
  parameter int AW = $clog2(N)
) (
  input  logic [AW-1:0] sel,
  output logic [N-1:0]  out
);

  assign out = N'(1) << sel;

endmodule

// File: rtl/proc_ctrl_unit.sv
// Multicycle control unit: latches an instruction into IR on run, then sequences
// register-file, A/G, DIN and ALU strobes over one to three execute steps.
module proc_ctrl_unit
  import proc_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int OP_W     = 3,
  parameter int DATA_W   = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [DATA_W-1:0]   din,
  input  logic                g_nz,
  output logic [DATA_W-1:0]   ir,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                a_in,
  output logic                g_in,
  output logic                g_out,
  output logic                din_out,
  output logic                ir_in,
  output logic [1:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [1:0]          state
);

  localparam int REG_AW = $clog2(NUM_REGS);

  generate
    if (DATA_W != OP_W + 2 * REG_AW) begin : g_bad_data_w
      $error("proc_ctrl_unit: DATA_W must equal OP_W + 2*REG_AW");
    end
    if (NUM_REGS < 2 || NUM_REGS > 16 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
      $error("proc_ctrl_unit: NUM_REGS must be a power of 2 in 2..16");
    end
    if (OP_W != 3) begin : g_bad_op_w
      $error("proc_ctrl_unit: opcode decode assumes a 3-bit opcode field");
    end
  endgenerate

  state_t               cur;
  logic [DATA_W-1:0]    ir_q;
  opcode_t              op;
  logic [REG_AW-1:0]    rx;
  logic [REG_AW-1:0]    ry;
  logic [NUM_REGS-1:0]  rx_oh;
  logic [NUM_REGS-1:0]  ry_oh;
  alu_op_t              alu_sel;

  assign op = opcode_t'(ir_q[DATA_W-1 -: OP_W]);
  assign rx = ir_q[2*REG_AW-1 -: REG_AW];
  assign ry = ir_q[REG_AW-1:0];

  onehot_dec #(.N(NUM_REGS), .AW(REG_AW)) u_dec_rx (.sel(rx), .out(rx_oh));
  onehot_dec #(.N(NUM_REGS), .AW(REG_AW)) u_dec_ry (.sel(ry), .out(ry_oh));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= S_IDLE;
      ir_q <= '0;
    end else begin
      if (ir_in) ir_q <= din;
      case (cur)
        S_IDLE:  if (run) cur <= S_T1;
        S_T1:    cur <= is_alu_op(op) ? S_T2 : S_IDLE;
        S_T2:    cur <= S_T3;
        default: cur <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would infer a latch.
  always_comb begin
    reg_in  = '0;
    reg_out = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    din_out = 1'b0;
    ir_in   = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    alu_sel = ALU_ADD;
    // Reset suppresses every strobe in the same cycle, aborting any write-back.
    if (!rst) begin
      case (cur)
        S_IDLE: ir_in = run;
        S_T1: begin
          case (op)
            OP_MV: begin
              reg_out = ry_oh;
              reg_in  = rx_oh;
              done    = 1'b1;
            end
            OP_MVI: begin
              din_out = 1'b1;
              reg_in  = rx_oh;
              done    = 1'b1;
            end
            OP_MVNZ: begin
              done = 1'b1;
              if (g_nz) begin
                reg_out = ry_oh;
                reg_in  = rx_oh;
              end
            end
            OP_ADD, OP_SUB, OP_AND: begin
              reg_out = rx_oh;
              a_in    = 1'b1;
            end
            default: begin
              done    = 1'b1;
              illegal = 1'b1;
            end
          endcase
        end
        S_T2: begin
          reg_out = ry_oh;
          g_in    = 1'b1;
          case (op)
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            default: alu_sel = ALU_ADD;
          endcase
        end
        default: begin
          g_out  = 1'b1;
          reg_in = rx_oh;
          done   = 1'b1;
        end
      endcase
    end
  end

  assign alu_op = alu_sel;
  assign busy   = !rst && (cur != S_IDLE);
  assign ir     = ir_q;
  assign state  = cur;

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Directed bench for proc_ctrl_unit: default 8-register build plus a 4-register build,
// each output set packed into one word and compared with hand-computed expectations.
module tb_proc_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word layout (shared by both builds)
  localparam logic [31:0] E_ILLEGAL = 32'h0000_0008;
  localparam logic [31:0] E_DONE    = 32'h0000_0010;
  localparam logic [31:0] E_BUSY    = 32'h0000_0020;
  localparam logic [31:0] E_IR_IN   = 32'h0000_0040;
  localparam logic [31:0] E_DIN_OUT = 32'h0000_0080;
  localparam logic [31:0] E_G_OUT   = 32'h0000_0100;
  localparam logic [31:0] E_G_IN    = 32'h0000_0200;
  localparam logic [31:0] E_A_IN    = 32'h0000_0400;
  localparam logic [31:0] E_ALU_SUB = 32'h0000_0800;
  localparam logic [31:0] E_ALU_AND = 32'h0000_1000;
  localparam logic [31:0] ST_T1     = 32'h0000_0001;
  localparam logic [31:0] ST_T2     = 32'h0000_0002;
  localparam logic [31:0] ST_T3     = 32'h0000_0003;

  // 8-register build
  logic       rst_8, run_8, g_nz_8;
  logic [8:0] din_8, ir_8;
  logic [7:0] reg_in_8, reg_out_8;
  logic       a_in_8, g_in_8, g_out_8, din_out_8, ir_in_8, busy_8, done_8, illegal_8;
  logic [1:0] alu_op_8, state_8;

  // 4-register build
  logic       rst_4, run_4, g_nz_4;
  logic [6:0] din_4, ir_4;
  logic [3:0] reg_in_4, reg_out_4;
  logic       a_in_4, g_in_4, g_out_4, din_out_4, ir_in_4, busy_4, done_4, illegal_4;
  logic [1:0] alu_op_4, state_4;

  proc_ctrl_unit dut8 (
    .clk(clk), .rst(rst_8), .run(run_8), .din(din_8), .g_nz(g_nz_8),
    .ir(ir_8), .reg_in(reg_in_8), .reg_out(reg_out_8),
    .a_in(a_in_8), .g_in(g_in_8), .g_out(g_out_8), .din_out(din_out_8), .ir_in(ir_in_8),
    .alu_op(alu_op_8), .busy(busy_8), .done(done_8), .illegal(illegal_8), .state(state_8)
  );

  proc_ctrl_unit #(.NUM_REGS(4), .OP_W(3), .DATA_W(7)) dut4 (
    .clk(clk), .rst(rst_4), .run(run_4), .din(din_4), .g_nz(g_nz_4),
    .ir(ir_4), .reg_in(reg_in_4), .reg_out(reg_out_4),
    .a_in(a_in_4), .g_in(g_in_4), .g_out(g_out_4), .din_out(din_out_4), .ir_in(ir_in_4),
    .alu_op(alu_op_4), .busy(busy_4), .done(done_4), .illegal(illegal_4), .state(state_4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] regs(input logic [7:0] ri, input logic [7:0] ro);
    return {ri, ro, 16'h0000};
  endfunction

  function automatic logic [31:0] snap8();
    return {reg_in_8, reg_out_8, 3'b000, alu_op_8, a_in_8, g_in_8, g_out_8, din_out_8,
            ir_in_8, busy_8, done_8, illegal_8, 1'b0, state_8};
  endfunction

  function automatic logic [31:0] snap4();
    return {4'h0, reg_in_4, 4'h0, reg_out_4, 3'b000, alu_op_4, a_in_4, g_in_4, g_out_4,
            din_out_4, ir_in_4, busy_4, done_4, illegal_4, 1'b0, state_4};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_8 = 1'b1; run_8 = 1'b0; din_8 = '0; g_nz_8 = 1'b0;
    rst_4 = 1'b1; run_4 = 1'b0; din_4 = '0; g_nz_4 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1 check("reset_ctrl", snap8(), 32'h0);
    check("reset_ir", 32'(ir_8), 32'h0);
    rst_8 = 1'b0; rst_4 = 1'b0;

    // mvi R3, #77
    @(negedge clk); run_8 = 1'b1; din_8 = 9'h058;
    #1 check("mvi_idle", snap8(), E_IR_IN);
    @(negedge clk); run_8 = 1'b0; din_8 = 9'd77;
    #1 check("mvi_t1", snap8(), regs(8'h08, 8'h00) | E_DIN_OUT | E_BUSY | E_DONE | ST_T1);
    check("mvi_ir", 32'(ir_8), 32'h058);
    @(negedge clk);
    #1 check("mvi_back_idle", snap8(), 32'h0);

    // add R1,R6 with run toggled mid-instruction
    @(negedge clk); run_8 = 1'b1; din_8 = 9'h08E;
    @(negedge clk); run_8 = 1'b0; din_8 = 9'h000;
    #1 check("add_t1", snap8(), regs(8'h00, 8'h02) | E_A_IN | E_BUSY | ST_T1);
    @(negedge clk); run_8 = 1'b1;
    #1 check("add_t2", snap8(), regs(8'h00, 8'h40) | E_G_IN | E_BUSY | ST_T2);
    @(negedge clk); run_8 = 1'b0;
    #1 check("add_t3", snap8(), regs(8'h02, 8'h00) | E_G_OUT | E_BUSY | E_DONE | ST_T3);
    check("add_ir_hold", 32'(ir_8), 32'h08E);
    @(negedge clk);
    #1 check("add_idle1", snap8(), 32'h0);
    @(negedge clk);
    #1 check("add_idle2", snap8(), 32'h0);

    // and R7,R0
    @(negedge clk); run_8 = 1'b1; din_8 = 9'h178;
    @(negedge clk); run_8 = 1'b0;
    #1 check("and_t1", snap8(), regs(8'h00, 8'h80) | E_A_IN | E_BUSY | ST_T1);
    @(negedge clk);
    #1 check("and_t2", snap8(), regs(8'h00, 8'h01) | E_G_IN | E_ALU_AND | E_BUSY | ST_T2);
    @(negedge clk);
    #1 check("and_t3", snap8(), regs(8'h80, 8'h00) | E_G_OUT | E_BUSY | E_DONE | ST_T3);
    @(negedge clk);

    // mvnz R2,R5 with G zero, then nonzero
    @(negedge clk); run_8 = 1'b1; din_8 = 9'h115; g_nz_8 = 1'b0;
    @(negedge clk); run_8 = 1'b0;
    #1 check("mvnz_z_t1", snap8(), E_BUSY | E_DONE | ST_T1);
    @(negedge clk); run_8 = 1'b1; g_nz_8 = 1'b1;
    @(negedge clk); run_8 = 1'b0;
    #1 check("mvnz_nz_t1", snap8(), regs(8'h04, 8'h20) | E_BUSY | E_DONE | ST_T1);
    @(negedge clk); g_nz_8 = 1'b0;

    // mv R0,R7 followed back-to-back by mvi R3
    @(negedge clk); run_8 = 1'b1; din_8 = 9'h007;
    @(negedge clk); din_8 = 9'h058;
    #1 check("mv_t1", snap8(), regs(8'h01, 8'h80) | E_BUSY | E_DONE | ST_T1);
    @(negedge clk);
    #1 check("b2b_idle", snap8(), E_IR_IN);
    @(negedge clk); run_8 = 1'b0; din_8 = 9'd5;
    #1 check("b2b_mvi_t1", snap8(), regs(8'h08, 8'h00) | E_DIN_OUT | E_BUSY | E_DONE | ST_T1);
    @(negedge clk);

    // Illegal opcode; run held high while busy must not reload IR
    @(negedge clk); run_8 = 1'b1; din_8 = 9'h1C0;
    @(negedge clk); din_8 = 9'h055;
    #1 check("ill_t1", snap8(), E_BUSY | E_DONE | E_ILLEGAL | ST_T1);
    @(negedge clk); run_8 = 1'b0;
    #1 check("ill_idle", snap8(), 32'h0);
    check("ill_ir", 32'(ir_8), 32'h1C0);

    // Reset asserted for two cycles during add T2
    @(negedge clk); run_8 = 1'b1; din_8 = 9'h08E;
    @(negedge clk); run_8 = 1'b0;
    @(negedge clk); rst_8 = 1'b1;
    #1 check("rst_in_t2", snap8(), ST_T2);
    @(negedge clk); run_8 = 1'b1;
    #1 check("rst_held", snap8(), 32'h0);
    check("rst_ir", 32'(ir_8), 32'h0);
    @(negedge clk); rst_8 = 1'b0; run_8 = 1'b0;
    #1 check("rst_release", snap8(), 32'h0);
    @(negedge clk);
    #1 check("rst_no_wb", snap8(), 32'h0);

    // 4-register build: sub R3,R0
    @(negedge clk); run_4 = 1'b1; din_4 = 7'h3C;
    @(negedge clk); run_4 = 1'b0;
    #1 check("p4_t1", snap4(), regs(8'h00, 8'h08) | E_A_IN | E_BUSY | ST_T1);
    @(negedge clk);
    #1 check("p4_t2", snap4(), regs(8'h00, 8'h01) | E_G_IN | E_ALU_SUB | E_BUSY | ST_T2);
    @(negedge clk);
    #1 check("p4_t3", snap4(), regs(8'h08, 8'h00) | E_G_OUT | E_BUSY | E_DONE | ST_T3);
    @(negedge clk);
    #1 check("p4_idle", snap4(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
